// File: rtl/bus_rd_arb_pkg.sv
// Shared constants for the tri-state read-bus arbiter: FSM encoding,
// default geometry and tenure counter width.
package bus_rd_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_TURN  = 2'b10;

  localparam int N_SRC_DEF = 4;
  localparam int OWN_W_DEF = 2;

  // Tenure counter width; bounds MAX_TENURE to 1..255.
  localparam int TEN_W = 8;

endpackage

// File: rtl/bus_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N_SRC.
module rr_pick
  import bus_rd_arb_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int OWN_W = OWN_W_DEF
) (
  input  logic [N_SRC-1:0] req,
  input  logic [OWN_W-1:0] ptr,
  output logic [N_SRC-1:0] win,
  output logic [OWN_W-1:0] win_idx,
  output logic             any
);

  logic found;
  int   j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N_SRC; i++) begin
      j = (int'(ptr) + i) % N_SRC;
      if (!found && req[j]) begin
        found   = 1'b1;
        win_idx = OWN_W'(j);
        win[j]  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_rd_arbiter.sv
// Round-robin owner sequencer for the shared 8-bit tri-state read bus, with a
// one-cycle all-off turnaround. Define BUS_RD_ARB_TIMEOUT_EN to enforce MAX_TENURE.
module bus_rd_arbiter
  import bus_rd_arb_pkg::*;
#(
  parameter int N_SRC      = N_SRC_DEF,
  parameter int OWN_W      = OWN_W_DEF,
  parameter int MAX_TENURE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] read_en,
  output logic [OWN_W-1:0] gnt_idx,
  output logic             bus_busy,
  output logic             timeout
);

  if (N_SRC < 2 || N_SRC > 8 || (1 << OWN_W) < N_SRC ||
      MAX_TENURE < 1 || MAX_TENURE > (1 << TEN_W) - 1) begin : g_bad_params
    $error("bus_rd_arbiter: illegal parameter combination");
  end

  logic [1:0]       state;
  logic [OWN_W-1:0] ptr;
  logic [N_SRC-1:0] win;
  logic [OWN_W-1:0] win_idx;
  logic             any;
  logic             drop;
  logic             forced;

  rr_pick #(
    .N_SRC (N_SRC),
    .OWN_W (OWN_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign drop     = ~req[gnt_idx];
  assign bus_busy = |read_en;

`ifdef BUS_RD_ARB_TIMEOUT_EN
  logic [TEN_W-1:0] count;

  assign forced = (count == TEN_W'(MAX_TENURE - 1));

  // count is zero on the first GRANT cycle because it is held clear outside GRANT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      count   <= (state == ST_GRANT) ? count + 1'b1 : '0;
      timeout <= (state == ST_GRANT) && forced;
    end
  end
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      read_en <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        ST_GRANT: begin
          // Other requesters are ignored here: no preemption of the owner.
          if (drop || forced) begin
            state   <= ST_TURN;
            read_en <= '0;
          end
        end
        default: begin
          // IDLE and TURN both arbitrate; TURN has already spent its off cycle.
          if (any) begin
            state   <= ST_GRANT;
            read_en <= win;
            gnt_idx <= win_idx;
            ptr     <= (win_idx == OWN_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
          end else begin
            state   <= ST_IDLE;
            read_en <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rd_arbiter.sv
// Directed self-checking bench for bus_rd_arbiter; timeout scenarios run only
// when BUS_RD_ARB_TIMEOUT_EN is defined.
module tb_bus_rd_arbiter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] read_en;
  logic [1:0] gnt_idx;
  logic       bus_busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_rd_arbiter #(
    .N_SRC      (4),
    .OWN_W      (2),
    .MAX_TENURE (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .read_en  (read_en),
    .gnt_idx  (gnt_idx),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  // Invariants checked every cycle out of reset.
  logic [3:0] prev_en = 4'b0000;
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if ($countones(read_en) > 1 || bus_busy !== (|read_en)) begin
        n_fail++;
        $display("FAIL invariant_onehot_busy: read_en=%b bus_busy=%b", read_en, bus_busy);
      end
      n_checks++;
      if (prev_en != 4'b0000 && read_en != 4'b0000 && prev_en != read_en) begin
        n_fail++;
        $display("FAIL invariant_turnaround: prev read_en=%b now read_en=%b, required a zero cycle", prev_en, read_en);
      end
`ifndef BUS_RD_ARB_TIMEOUT_EN
      n_checks++;
      if (timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_tied_low: timeout=%b required 0", timeout);
      end
`endif
      prev_en = read_en;
    end else begin
      prev_en = 4'b0000;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    @(negedge clk);
    n_checks++;
    if ({read_en, gnt_idx, bus_busy, timeout} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL reset_outputs: read_en=%b gnt_idx=%0d busy=%b timeout=%b, required all 0",
               read_en, gnt_idx, bus_busy, timeout);
    end
    @(negedge clk);
    n_checks++;
    if (read_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_holds: read_en=%b required 0000 while rst_n low", read_en);
    end
    req   = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (read_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle: read_en=%b required 0000", read_en);
    end
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({read_en, gnt_idx, bus_busy} !== {4'b0100, 2'd2, 1'b1}) begin
        n_fail++;
        $display("FAIL single_grant[%0d]: read_en=%b gnt_idx=%0d busy=%b, required 0100/2/1",
                 c, read_en, gnt_idx, bus_busy);
      end
    end
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({read_en, bus_busy} !== 5'b0000_0) begin
        n_fail++;
        $display("FAIL single_release[%0d]: read_en=%b busy=%b, required 0000/0", c, read_en, bus_busy);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_en;
    logic [1:0] exp_idx;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_idx = 2'(k % 4);
      exp_en  = 4'b0001 << (k % 4);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        n_checks++;
        if ({read_en, gnt_idx} !== {exp_en, exp_idx}) begin
          n_fail++;
          $display("FAIL rr_grant[%0d.%0d]: read_en=%b gnt_idx=%0d, required %b/%0d",
                   k, c, read_en, gnt_idx, exp_en, exp_idx);
        end
      end
      req = req & ~exp_en;
      @(negedge clk);
      n_checks++;
      if (read_en !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_turn[%0d]: read_en=%b required 0000", k, read_en);
      end
      req = 4'b1111;
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if ({read_en, gnt_idx} !== {4'b0010, 2'd1}) begin
      n_fail++;
      $display("FAIL np_first: read_en=%b gnt_idx=%0d, required 0010/1", read_en, gnt_idx);
    end
    req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({read_en, gnt_idx} !== {4'b0010, 2'd1}) begin
        n_fail++;
        $display("FAIL np_hold[%0d]: read_en=%b gnt_idx=%0d, required 0010/1", c, read_en, gnt_idx);
      end
    end
    req = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (read_en !== 4'b0000) begin
      n_fail++;
      $display("FAIL np_turn: read_en=%b required 0000", read_en);
    end
    @(negedge clk);
    n_checks++;
    if ({read_en, gnt_idx} !== {4'b1000, 2'd3}) begin
      n_fail++;
      $display("FAIL np_next: read_en=%b gnt_idx=%0d, required 1000/3", read_en, gnt_idx);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (read_en !== 4'b0010) begin
      n_fail++;
      $display("FAIL ar_pre: read_en=%b required 0010", read_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({read_en, bus_busy} !== 5'b0000_0) begin
      n_fail++;
      $display("FAIL ar_immediate: read_en=%b busy=%b before next edge, required 0000/0", read_en, bus_busy);
    end
    // ptr was 2 before reset; src1 winning over src3 shows it returned to 0
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({read_en, gnt_idx} !== {4'b0010, 2'd1}) begin
      n_fail++;
      $display("FAIL ar_ptr_cleared: read_en=%b gnt_idx=%0d, required 0010/1", read_en, gnt_idx);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    req   = 4'b1000;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({read_en, gnt_idx} !== {4'b1000, 2'd3}) begin
      n_fail++;
      $display("FAIL ar_src3: read_en=%b gnt_idx=%0d, required 1000/3", read_en, gnt_idx);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

`ifdef BUS_RD_ARB_TIMEOUT_EN
  task automatic test_timeout_single();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if ({read_en, timeout} !== 5'b0001_0) begin
        n_fail++;
        $display("FAIL to_single_grant[%0d]: read_en=%b timeout=%b, required 0001/0", c, read_en, timeout);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({read_en, timeout} !== 5'b0000_1) begin
      n_fail++;
      $display("FAIL to_single_release: read_en=%b timeout=%b, required 0000/1", read_en, timeout);
    end
    @(negedge clk);
    n_checks++;
    if ({read_en, timeout} !== 5'b0001_0) begin
      n_fail++;
      $display("FAIL to_single_regrant: read_en=%b timeout=%b, required 0001/0", read_en, timeout);
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout_pair();
    logic [3:0] exp_en;
    do_reset();
    req = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      exp_en = 4'b0001 << k;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        n_checks++;
        if ({read_en, gnt_idx} !== {exp_en, 2'(k)}) begin
          n_fail++;
          $display("FAIL to_pair_grant[%0d.%0d]: read_en=%b gnt_idx=%0d, required %b/%0d",
                   k, c, read_en, gnt_idx, exp_en, k);
        end
      end
      @(negedge clk);
      n_checks++;
      if ({read_en, timeout} !== 5'b0000_1) begin
        n_fail++;
        $display("FAIL to_pair_turn[%0d]: read_en=%b timeout=%b, required 0000/1", k, read_en, timeout);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({read_en, gnt_idx} !== {4'b0001, 2'd0}) begin
      n_fail++;
      $display("FAIL to_pair_back: read_en=%b gnt_idx=%0d, required 0001/0", read_en, gnt_idx);
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_async_reset();
`ifdef BUS_RD_ARB_TIMEOUT_EN
    test_timeout_single();
    test_timeout_pair();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
